ins_uart_loader: RTL and testbench
==================================

Name: ins_uart_loader

Overview:
- Serial instruction loader that writes program words into the processor's instruction-memory write port (W_Ins / WE) from a host over UART.
- Receives 8N1 bytes, assembles big-endian 32-bit words and issues one write strobe per word with an auto-incrementing word address.
- Sits on the board top between the RX pin and the processor's write port.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 4.
- ADDR_W, 8, width of the word-address counter.
- IDLE_CLKS, 50000, gap in clocks after which a partially assembled word is discarded.

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous active-high reset.
- RXD  input  1  asynchronous UART line, idle high.
- LOAD_EN  input  1  1 = accept bytes; 0 = receiver held idle, no writes.
- ADDR_CLR  input  1  one-cycle pulse: address counter and byte count go to 0.
- W_Ins  output  32  assembled instruction word.
- WE  output  1  one-cycle write strobe; W_Ins and W_ADDR valid while high.
- W_ADDR  output  ADDR_W  word address of the current write.
- FERR  output  1  one-cycle pulse on a framing error (stop bit sampled 0).
- WCNT  output  16  total words written since reset, saturating at 0xFFFF.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - Outputs: W_Ins=0, WE=0, W_ADDR=0, FERR=0, WCNT=0.
  - Internal: byte count=0, FSM=IDLE, synchronizer flops=1.
  - Reset mid-frame or mid-word aborts everything; no write is issued.
- Synchronizer: RXD passes through 2 flops (rx_s); all logic uses rx_s.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: on rx_s=0 with LOAD_EN=1, go to START and clear the bit timer.
  - START: after CLKS_PER_BIT/2 cycles, sample rx_s. If 0, go to DATA with bit index 0. If 1 (glitch), return to IDLE with no error.
  - DATA: every CLKS_PER_BIT cycles, sample one bit, LSB first. After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - 1: byte valid; go to IDLE.
    - 0: pulse FERR for 1 cycle, discard the byte (byte count unchanged), go to IDLE only after rx_s returns to 1.
- LOAD_EN=0 at any time: FSM forced to IDLE, current frame discarded, byte count kept.
- Word assembly:
  - Valid bytes shift in big-endian: the first byte lands in bits [31:24], the fourth in [7:0].
  - On the 4th valid byte, in the cycle after the stop-bit sample:
    - WE=1 for exactly 1 cycle.
    - W_Ins = assembled word.
    - W_ADDR = current address.
  - In the following cycle: address +1 (wraps 2^ADDR_W-1 -> 0), byte count=0, WCNT +1 (saturating).
  - W_Ins holds its last value while WE=0.
- Idle timeout: if byte count is nonzero and no valid byte arrives for IDLE_CLKS cycles, byte count -> 0 with no write. The counter restarts on every valid byte.
- ADDR_CLR:
  - Sets the address and byte count to 0 the next cycle.
  - If ADDR_CLR coincides with a WE cycle, the write completes at the old address and the address becomes 0, not old+1.
- Latency: WE asserts 1 cycle after the 4th stop-bit sample point, i.e. ~9.5 bit times after that byte's start edge plus 3 clocks (2 synchronizer + 1 register).
- FERR and WE are never high in the same cycle.

Test Plan:
- Setup for all scenarios: CLKS_PER_BIT=8, IDLE_CLKS=200.
- Basic word: after reset, send bytes 0x20,0x08,0x00,0x05 -> single WE pulse, W_Ins=0x20080005, W_ADDR=0; then W_ADDR=1, WCNT=1.
- Multi-word and wrap: with ADDR_W=2, send 5 words -> WE addresses 0,1,2,3,0; WCNT=5.
- Framing error: send 0x12, then 0x34 with stop bit low, then 0x34,0x56,0x78 -> one FERR pulse; one write with W_Ins=0x12345678.
- Timeout: send 0x AA,0xBB, wait 250 clocks, send 0x00,0x00,0x00,0x01 -> one write, W_Ins=0x00000001 (no 0xAABB0000 prefix).
- Glitch and LOAD_EN:
  - A 2-clock low pulse on RXD gives no byte and no FERR.
  - LOAD_EN=0 while a full frame is sent gives no byte accepted.
- Reset and clear:
  - Assert RST after 3 bytes, then send 4 bytes -> one write at W_ADDR=0 with the new word.
  - ADDR_CLR pulsed on a WE cycle at addr 5 -> write at 5, next write at 0.

Source files
------------

// File: rtl/ins_uart_loader.sv
// UART (8N1) instruction loader: assembles big-endian 32-bit words from received
// bytes and writes them to the instruction memory at an auto-incrementing address.
module ins_uart_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 8,
  parameter int IDLE_CLKS    = 50000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RXD,
  input  logic              LOAD_EN,
  input  logic              ADDR_CLR,
  output logic [31:0]       W_Ins,
  output logic              WE,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic              FERR,
  output logic [15:0]       WCNT
);
  localparam int TW = $clog2(CLKS_PER_BIT) + 1;
  localparam int IW = $clog2(IDLE_CLKS) + 1;
  localparam logic [TW-1:0]     TMR_ONE   = TW'(1);
  localparam logic [TW-1:0]     BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0]     HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0]     IDLE_ONE  = IW'(1);
  localparam logic [IW-1:0]     IDLE_LAST = IW'(IDLE_CLKS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic          sync1, rx_s;
  logic [TW-1:0] tmr, tmr_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          brk, brk_n;
  logic          byte_ok, ferr_s;
  logic [1:0]    byte_cnt;
  logic [23:0]   word;
  logic [IW-1:0] idle_cnt;

  // Receiver next-state logic; brk holds STOP after a framing error until the line idles.
  always_comb begin
    state_n = state;
    tmr_n   = tmr + TMR_ONE;
    idx_n   = idx;
    shreg_n = shreg;
    brk_n   = brk;
    byte_ok = 1'b0;
    ferr_s  = 1'b0;
    if (!LOAD_EN) begin
      state_n = IDLE;
      tmr_n   = '0;
      brk_n   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tmr_n = '0;
          if (!rx_s) state_n = START;
          else       state_n = IDLE;
        end
        START: begin
          if (tmr == HALF_LAST) begin
            tmr_n   = '0;
            idx_n   = 3'd0;
            state_n = rx_s ? IDLE : DATA;
          end else begin
            state_n = START;
          end
        end
        DATA: begin
          if (tmr == BIT_LAST) begin
            tmr_n   = '0;
            shreg_n = {rx_s, shreg[7:1]};
            idx_n   = idx + 3'd1;
            state_n = (idx == 3'd7) ? STOP : DATA;
          end else begin
            state_n = DATA;
          end
        end
        STOP: begin
          if (brk) begin
            tmr_n = '0;
            if (rx_s) begin
              brk_n   = 1'b0;
              state_n = IDLE;
            end else begin
              state_n = STOP;
            end
          end else if (tmr == BIT_LAST) begin
            tmr_n = '0;
            if (rx_s) begin
              byte_ok = 1'b1;
              state_n = IDLE;
            end else begin
              ferr_s = 1'b1;
              brk_n  = 1'b1;
            end
          end else begin
            state_n = STOP;
          end
        end
        default: begin
          state_n = IDLE;
          tmr_n   = '0;
          brk_n   = 1'b0;
        end
      endcase
    end
  end

  // Receiver state, word assembly, idle timeout, address and write-count registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1    <= 1'b1;
      rx_s     <= 1'b1;
      state    <= IDLE;
      tmr      <= '0;
      idx      <= 3'd0;
      shreg    <= 8'd0;
      brk      <= 1'b0;
      byte_cnt <= 2'd0;
      word     <= 24'd0;
      idle_cnt <= '0;
      W_Ins    <= 32'd0;
      WE       <= 1'b0;
      W_ADDR   <= '0;
      FERR     <= 1'b0;
      WCNT     <= 16'd0;
    end else begin
      sync1 <= RXD;
      rx_s  <= sync1;
      state <= state_n;
      tmr   <= tmr_n;
      idx   <= idx_n;
      shreg <= shreg_n;
      brk   <= brk_n;
      FERR  <= ferr_s;
      WE    <= 1'b0;

      if (WE) begin
        byte_cnt <= 2'd0;
        idle_cnt <= '0;
      end else if (byte_ok) begin
        idle_cnt <= '0;
        if (byte_cnt == 2'd3) begin
          WE    <= 1'b1;
          W_Ins <= {word, shreg_n};
        end else begin
          byte_cnt <= byte_cnt + 2'd1;
          word     <= {word[15:0], shreg_n};
        end
      end else if (byte_cnt != 2'd0) begin
        if (idle_cnt == IDLE_LAST) begin
          byte_cnt <= 2'd0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + IDLE_ONE;
        end
      end else begin
        idle_cnt <= '0;
      end

      // A clear overrides both the byte count and the post-write increment.
      if (ADDR_CLR) begin
        byte_cnt <= 2'd0;
        W_ADDR   <= '0;
      end else if (WE) begin
        W_ADDR <= W_ADDR + ADDR_ONE;
      end else begin
        W_ADDR <= W_ADDR;
      end

      if (WE && (WCNT != 16'hFFFF)) WCNT <= WCNT + 16'd1;
      else                          WCNT <= WCNT;
    end
  end
endmodule

// File: tb/tb_ins_uart_loader.sv
// Self-checking bench: two loaders (ADDR_W=8 and ADDR_W=2) share one UART line and are
// compared against a byte/word-level reference model of the loader protocol.
module tb_ins_uart_loader;
  localparam int CPB  = 8;
  localparam int IDLE = 200;

  logic        clk = 1'b0;
  logic        rst, rxd, load_en, addr_clr;
  logic [31:0] w_ins_a, w_ins_b;
  logic        we_a, we_b, ferr_a, ferr_b;
  logic [7:0]  w_addr_a;
  logic [1:0]  w_addr_b;
  logic [15:0] wcnt_a, wcnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {logic [31:0] word; int addr;} wr_t;
  wr_t exp_q[$];
  int  byte_q[$];
  int  m_addr = 0, m_wcnt = 0, m_ferr = 0, ferr_seen = 0;

  always #5 clk = ~clk;

  ins_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(8), .IDLE_CLKS(IDLE)) dut_a (
    .CLK(clk), .RST(rst), .RXD(rxd), .LOAD_EN(load_en), .ADDR_CLR(addr_clr),
    .W_Ins(w_ins_a), .WE(we_a), .W_ADDR(w_addr_a), .FERR(ferr_a), .WCNT(wcnt_a));

  ins_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(2), .IDLE_CLKS(IDLE)) dut_b (
    .CLK(clk), .RST(rst), .RXD(rxd), .LOAD_EN(load_en), .ADDR_CLR(addr_clr),
    .W_Ins(w_ins_b), .WE(we_b), .W_ADDR(w_addr_b), .FERR(ferr_b), .WCNT(wcnt_b));

  // Reference model: every 4 valid bytes form one big-endian word at the next address.
  function automatic void model_byte(input int b);
    wr_t w;
    byte_q.push_back(b);
    if (byte_q.size() == 4) begin
      w.word = 32'(byte_q[0] * 16777216 + byte_q[1] * 65536 + byte_q[2] * 256 + byte_q[3]);
      w.addr = m_addr;
      exp_q.push_back(w);
      m_addr = m_addr + 1;
      m_wcnt = (m_wcnt < 65535) ? m_wcnt + 1 : 65535;
      byte_q.delete();
    end
  endfunction

  // Write / framing-error monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    wr_t e;
    if (ferr_a) ferr_seen++;
    if (we_a || we_b || ferr_a) begin
      n_tests++;
      assert (!(we_a && ferr_a) && (we_a === we_b)) else begin
        n_fail++; $error("FAIL we_ferr_excl we_a=%b we_b=%b ferr=%b required we_a==we_b, no overlap", we_a, we_b, ferr_a);
      end
    end
    if (we_a) begin
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++; $error("FAIL unexpected_write got W_Ins=%h W_ADDR=%0d required no write", w_ins_a, w_addr_a);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_tests += 3;
        assert (w_ins_a === e.word && w_ins_b === e.word) else begin
          n_fail++; $error("FAIL w_ins got %h/%h required %h", w_ins_a, w_ins_b, e.word);
        end
        assert (w_addr_a === 8'(e.addr % 256)) else begin
          n_fail++; $error("FAIL w_addr_a got %0d required %0d", w_addr_a, e.addr % 256);
        end
        assert (w_addr_b === 2'(e.addr % 4)) else begin
          n_fail++; $error("FAIL w_addr_b got %0d required %0d", w_addr_b, e.addr % 4);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i]; tick(CPB);
    end
    rxd = stop_bit; tick(CPB);
    rxd = 1'b1; tick(CPB);
  endtask

  task automatic send_good(input logic [7:0] b);
    model_byte(int'(b));
    send_frame(b, 1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_good(w[i*8 +: 8]);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(2); rst = 1'b0;
    byte_q.delete(); m_addr = 0; m_wcnt = 0;
  endtask

  task automatic check_end(input string tag);
    tick(40);
    n_tests += 5;
    assert (exp_q.size() == 0) else begin
      n_fail++; $error("FAIL %s_pending got %0d missing writes required 0", tag, exp_q.size());
    end
    assert (wcnt_a === 16'(m_wcnt) && wcnt_b === 16'(m_wcnt)) else begin
      n_fail++; $error("FAIL %s_wcnt got %0d/%0d required %0d", tag, wcnt_a, wcnt_b, m_wcnt);
    end
    assert (w_addr_a === 8'(m_addr % 256)) else begin
      n_fail++; $error("FAIL %s_addr_a got %0d required %0d", tag, w_addr_a, m_addr % 256);
    end
    assert (w_addr_b === 2'(m_addr % 4)) else begin
      n_fail++; $error("FAIL %s_addr_b got %0d required %0d", tag, w_addr_b, m_addr % 4);
    end
    assert (ferr_seen == m_ferr) else begin
      n_fail++; $error("FAIL %s_ferr got %0d pulses required %0d", tag, ferr_seen, m_ferr);
    end
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    bit seen;
    rst = 1'b0; rxd = 1'b1; load_en = 1'b1; addr_clr = 1'b0;
    tick(1);
    do_reset();
    n_tests++;
    assert (w_ins_a === 32'd0 && we_a === 1'b0 && w_addr_a === 8'd0 && ferr_a === 1'b0 && wcnt_a === 16'd0) else begin
      n_fail++; $error("FAIL reset got ins=%h we=%b addr=%0d ferr=%b wcnt=%0d required all 0", w_ins_a, we_a, w_addr_a, ferr_a, wcnt_a);
    end

    // Basic word
    send_word(32'h20080005);
    check_end("basic");

    // Multi-word with address wrap on the 2-bit instance
    do_reset();
    for (int i = 0; i < 5; i++) send_word($urandom);
    check_end("wrap");

    // Framing error: bad-stop byte is dropped
    send_good(8'h12);
    m_ferr++;
    send_frame(8'h34, 1'b0);
    send_good(8'h34); send_good(8'h56); send_good(8'h78);
    check_end("ferr");

    // Idle timeout discards the partial word
    send_good(8'hAA); send_good(8'hBB);
    tick(250);
    byte_q.delete();
    send_word(32'h00000001);
    check_end("timeout");

    // Glitch, then a frame sent while disabled keeps the byte count
    rxd = 1'b0; tick(2); rxd = 1'b1; tick(30);
    send_good(8'($urandom));
    load_en = 1'b0;
    send_frame(8'h5A, 1'b1);
    load_en = 1'b1;
    for (int i = 0; i < 3; i++) send_good(8'($urandom));
    check_end("glitch_en");

    // Reset mid-word
    for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1);
    do_reset();
    send_word($urandom);
    check_end("rst_mid");

    // ADDR_CLR coinciding with the write at address 5
    for (int i = 0; i < 4; i++) send_word($urandom);
    w = $urandom;
    seen = 1'b0;
    fork
      send_word(w);
      begin
        for (int k = 0; k < 2000 && !seen; k++) begin
          @(negedge clk);
          if (we_a) begin
            seen = 1'b1;
            addr_clr = 1'b1;
            @(negedge clk);
            addr_clr = 1'b0;
          end
        end
      end
    join
    n_tests++;
    assert (seen) else begin
      n_fail++; $error("FAIL clr_we_wait got no write required one within bound");
    end
    m_addr = 0;
    byte_q.delete();
    send_word($urandom);
    check_end("addr_clr");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
